// File: rtl/mul_pipe_unit.sv
// Stallable, flushable pipelined RV32M multiplier with per-stage destination
// tags and pending-destination hazard reporting for the ID stage.
module mul_pipe_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic [TAG_W-1:0]  rd_i,
  input  logic [TAG_W-1:0]  q_rs1,
  input  logic [TAG_W-1:0]  q_rs2,
  output logic              valid_o,
  output logic [WIDTH-1:0]  result,
  output logic [TAG_W-1:0]  rd_o,
  output logic              busy,
  output logic              pend_hit
);

  // Only the low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) product are ever
  // selected, so the product is formed modulo 2^(2*WIDTH).
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic                    a_signed;
  logic                    b_signed;
  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   b_ext;
  logic signed [PW-1:0]    prod;
  logic [WIDTH-1:0]        res_c;

  logic [STAGES-1:0]       vld;
  logic [TAG_W-1:0]        tag [STAGES];
  logic [WIDTH-1:0]        dat [STAGES];

  logic                    advance;

  // Operand sign extension, product and result-slice selection.
  always_comb begin
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU);
    b_signed = (op_i == OP_MULH);
    a_ext    = {a_signed & opA[WIDTH-1], opA};
    b_ext    = {b_signed & opB[WIDTH-1], opB};
    prod     = PW'(a_ext) * PW'(b_ext);
    if (op_i == OP_MUL) begin
      res_c = prod[WIDTH-1:0];
    end else begin
      res_c = prod[PW-1:WIDTH];
    end
  end

  assign advance = !stall && !flush;

  // Per-stage valid/tag/data registers; data and tag load only behind a valid.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld[0] <= 1'b0;
          tag[0] <= '0;
          dat[0] <= '0;
        end else if (flush) begin
          vld[0] <= 1'b0;
        end else if (advance) begin
          vld[0] <= valid_i;
          if (valid_i) begin
            tag[0] <= rd_i;
            dat[0] <= res_c;
          end
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld[g] <= 1'b0;
          tag[g] <= '0;
          dat[g] <= '0;
        end else if (flush) begin
          vld[g] <= 1'b0;
        end else if (advance) begin
          vld[g] <= vld[g-1];
          if (vld[g-1]) begin
            tag[g] <= tag[g-1];
            dat[g] <= dat[g-1];
          end
        end
      end
    end
  end

  assign valid_o = vld[STAGES-1];
  assign result  = dat[STAGES-1];
  assign rd_o    = tag[STAGES-1];
  assign busy    = |vld;

  // Pending-destination match against the two ID-stage source queries.
  always_comb begin
    pend_hit = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (vld[k] && (q_rs1 != '0) && (tag[k] == q_rs1)) pend_hit = 1'b1;
      if (vld[k] && (q_rs2 != '0) && (tag[k] == q_rs2)) pend_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: a STAGES=2 instance for function, latency,
// stall, flush and hazard behaviour, and a STAGES=4 instance for async reset.
module tb_mul_pipe_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 5;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic              valid_i;
  logic [1:0]        op_i;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [TAG_W-1:0]  rd_i;
  logic [TAG_W-1:0]  q_rs1;
  logic [TAG_W-1:0]  q_rs2;

  logic              valid_o,  busy,  pend_hit;
  logic [WIDTH-1:0]  result;
  logic [TAG_W-1:0]  rd_o;
  logic              valid_o4, busy4, pend_hit4;
  logic [WIDTH-1:0]  result4;
  logic [TAG_W-1:0]  rd_o4;

  int checks;
  int failures;

  mul_pipe_unit #(.WIDTH(WIDTH), .STAGES(2), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_i(valid_i), .op_i(op_i), .opA(opA), .opB(opB), .rd_i(rd_i),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .valid_o(valid_o), .result(result), .rd_o(rd_o),
    .busy(busy), .pend_hit(pend_hit)
  );

  mul_pipe_unit #(.WIDTH(WIDTH), .STAGES(4), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_i(valid_i), .op_i(op_i), .opA(opA), .opB(opB), .rd_i(rd_i),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .valid_o(valid_o4), .result(result4), .rd_o(rd_o4),
    .busy(busy4), .pend_hit(pend_hit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] rd);
    valid_i = 1'b1;
    op_i    = op;
    opA     = a;
    opB     = b;
    rd_i    = rd;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    op_i    = 2'b00;
    opA     = '0;
    opB     = '0;
    rd_i    = '0;
  endtask

  // Issue one op and check it appears exactly two edges later with its tag.
  task automatic mode_test(input string name, input logic [1:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [TAG_W-1:0] rd, input logic [WIDTH-1:0] exp);
    issue(op, a, b, rd);
    tick();
    idle();
    check({name, "_early"}, 64'(valid_o), 64'd0);
    tick();
    check({name, "_valid"}, 64'(valid_o), 64'd1);
    check({name, "_result"}, 64'(result), 64'(exp));
    check({name, "_rd"}, 64'(rd_o), 64'(rd));
    tick();
    check({name, "_drop"}, 64'(valid_o), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    q_rs1    = '0;
    q_rs2    = '0;
    idle();

    // Reset state
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd_o", 64'(rd_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pend_hit", 64'(pend_hit), 64'd0);
    #11;
    rst_n = 1'b1;
    tick();

    // All four multiply modes
    mode_test("mul",    2'b00, 32'h7FFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFE);
    mode_test("mulh",   2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    mode_test("mulhu",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    mode_test("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    mode_test("mulh_neg", 2'b01, 32'hFFFF_FFFF, 32'h0000_0005, 5'd5, 32'hFFFF_FFFF);

    // Back-to-back issue, tags 3,4,5 retire in order
    issue(2'b00, 32'd2, 32'd3, 5'd3);
    tick();
    check("b2b_e0_valid", 64'(valid_o), 64'd0);
    issue(2'b00, 32'd2, 32'd4, 5'd4);
    tick();
    check("b2b_e1_rd", 64'(rd_o), 64'd3);
    check("b2b_e1_res", 64'(result), 64'd6);
    check("b2b_e1_valid", 64'(valid_o), 64'd1);
    issue(2'b00, 32'd2, 32'd5, 5'd5);
    tick();
    idle();
    check("b2b_e2_rd", 64'(rd_o), 64'd4);
    check("b2b_e2_res", 64'(result), 64'd8);
    check("b2b_e2_valid", 64'(valid_o), 64'd1);
    tick();
    check("b2b_e3_rd", 64'(rd_o), 64'd5);
    check("b2b_e3_res", 64'(result), 64'd10);
    check("b2b_e3_valid", 64'(valid_o), 64'd1);
    tick();
    check("b2b_e4_valid", 64'(valid_o), 64'd0);
    check("b2b_e4_busy", 64'(busy), 64'd0);

    // Stall for three cycles after issuing tag 7
    issue(2'b00, 32'd5, 32'd6, 5'd7);
    tick();
    idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;                // must be ignored while stalled
      rd_i    = 5'd12;
      tick();
      check("stall_valid_o", 64'(valid_o), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
    end
    idle();
    stall = 1'b0;
    tick();
    check("stall_out_valid", 64'(valid_o), 64'd1);
    check("stall_out_rd", 64'(rd_o), 64'd7);
    check("stall_out_res", 64'(result), 64'd30);
    stall = 1'b1;
    tick();
    check("hold_valid", 64'(valid_o), 64'd1);
    check("hold_res", 64'(result), 64'd30);
    stall = 1'b0;
    tick();
    check("hold_drop", 64'(valid_o), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);

    // Flush beats stall and drops a coinciding issue
    issue(2'b00, 32'd7, 32'd7, 5'd1);
    tick();
    issue(2'b00, 32'd8, 32'd8, 5'd2);
    tick();
    check("flush_pre_busy", 64'(busy), 64'd1);
    issue(2'b00, 32'd9, 32'd9, 5'd6);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid_o", 64'(valid_o), 64'd0);
    tick();
    check("flush_late_valid", 64'(valid_o), 64'd0);
    tick();
    check("flush_late2_valid", 64'(valid_o), 64'd0);

    // Hazard tracking on tag 9, and tag 0 never hits
    q_rs1 = 5'd9;
    issue(2'b00, 32'd1, 32'd1, 5'd9);
    #1;
    check("haz_empty", 64'(pend_hit), 64'd0);
    tick();
    idle();
    check("haz_s0", 64'(pend_hit), 64'd1);
    q_rs1 = 5'd8;
    #1;
    check("haz_other_tag", 64'(pend_hit), 64'd0);
    q_rs1 = 5'd0;
    q_rs2 = 5'd9;
    #1;
    check("haz_rs2", 64'(pend_hit), 64'd1);
    q_rs2 = 5'd0;
    q_rs1 = 5'd9;
    tick();
    check("haz_s1", 64'(pend_hit), 64'd1);
    tick();
    check("haz_retired", 64'(pend_hit), 64'd0);
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
    issue(2'b00, 32'd1, 32'd1, 5'd0);
    tick();
    idle();
    check("haz_zero_busy", 64'(busy), 64'd1);
    check("haz_zero_tag", 64'(pend_hit), 64'd0);
    tick();
    tick();

    // Asynchronous reset with the 4-stage instance fully loaded
    for (int i = 1; i <= 4; i++) begin
      issue(2'b00, 32'(i), 32'd3, 5'(i));
      tick();
    end
    idle();
    q_rs1 = 5'd2;
    check("s4_loaded_valid", 64'(valid_o4), 64'd1);
    check("s4_loaded_rd", 64'(rd_o4), 64'd1);
    check("s4_loaded_res", 64'(result4), 64'd3);
    #1;
    check("s4_loaded_hit", 64'(pend_hit4), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid_o", 64'(valid_o4), 64'd0);
    check("arst_result", 64'(result4), 64'd0);
    check("arst_rd_o", 64'(rd_o4), 64'd0);
    check("arst_busy", 64'(busy4), 64'd0);
    check("arst_pend_hit", 64'(pend_hit4), 64'd0);
    check("arst_busy2", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
